// File: rtl/robot_pkg.sv
// Shared definitions for the robot line-sensor path.
// Holds the default sensor vector width, the debounce FSM state type and the
// sensor bit positions, so the debounce stage and the steering decoder agree
// on which bit is which.
package robot_pkg;

  localparam int WIDTH = 5;

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } dbnc_state_t;

  // Sensor bit positions, left to right across the robot's nose.
  localparam int S_FAR_L = 4;
  localparam int S_L     = 3;
  localparam int S_C     = 2;
  localparam int S_R     = 1;
  localparam int S_FAR_R = 0;

endpackage

// File: rtl/bit_debounce.sv
// Single-bit synchronizer + debouncer.
// Ports:
//   clk, reset  clock / async active-low reset
//   tick        sample-rate enable
//   run         1 = debounce mode; 0 = warm-up (stable bit tracks sy on tick)
//   raw         asynchronous sensor line
//   s           debounced stable bit
//   upd         combinational: s takes a new value on this edge
module bit_debounce #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = $clog2(DEBOUNCE)
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic run,
  input  logic raw,
  output logic s,
  output logic upd
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic             sync1, sy;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s_nxt;

  always_comb begin
    s_nxt   = s;
    cnt_nxt = cnt;
    if (!run) begin
      // Warm-up: follow the synchronizer directly, no counting.
      cnt_nxt = '0;
      if (tick) s_nxt = sy;
    end else if (sy == s) begin
      // Agreement clears progress on any edge, tick or not.
      cnt_nxt = '0;
    end else if (tick) begin
      if (cnt == CNT_MAX) begin
        s_nxt   = sy;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  assign upd = (s_nxt != s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sy    <= 1'b0;
      s     <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sy    <= sync1;
      s     <= s_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/sensor_debounce.sv
// Line-sensor front end: synchronizes and debounces each sensor bit and
// presents a stable vector to the steering decoder.
// Ports:
//   clk      system clock
//   reset    async active-low reset
//   tick     sample-rate enable
//   raw      asynchronous sensor inputs [WIDTH]
//   s        debounced sensor vector [WIDTH]
//   valid    warm-up complete, held until reset
//   changed  one-cycle pulse when s updates in RUN
module sensor_debounce #(
  parameter int WIDTH    = robot_pkg::WIDTH,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = $clog2(DEBOUNCE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] s,
  output logic             valid,
  output logic             changed
);
  import robot_pkg::*;

  localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(DEBOUNCE - 1);

  dbnc_state_t      state, state_nxt;
  logic [CNT_W-1:0] warm, warm_nxt;
  logic             valid_nxt, changed_nxt;
  logic             run;
  logic [WIDTH-1:0] upd;

  assign run = (state == RUN);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bit_debounce #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .run   (run),
      .raw   (raw[i]),
      .s     (s[i]),
      .upd   (upd[i])
    );
  end

  always_comb begin
    state_nxt   = state;
    warm_nxt    = warm;
    valid_nxt   = valid;
    // Warm-up loads are not reported as changes.
    changed_nxt = run && (|upd);
    case (state)
      WARMUP: begin
        if (tick) begin
          if (warm == WARM_MAX) begin
            state_nxt = RUN;
            valid_nxt = 1'b1;
          end else begin
            warm_nxt = warm + CNT_W'(1);
          end
        end
      end
      RUN: ;
      default: state_nxt = WARMUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= WARMUP;
      warm    <= '0;
      valid   <= 1'b0;
      changed <= 1'b0;
    end else begin
      state   <= state_nxt;
      warm    <= warm_nxt;
      valid   <= valid_nxt;
      changed <= changed_nxt;
    end
  end

endmodule

// File: tb/tb_sensor_debounce.sv
module tb_sensor_debounce;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [4:0] raw;
  logic [4:0] s;
  logic       valid;
  logic       changed;

  int n_chk = 0;
  int n_err = 0;

  sensor_debounce #(.WIDTH(5), .DEBOUNCE(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .raw     (raw),
    .s       (s),
    .valid   (valid),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    tick  = 1'b1;
    raw   = 5'b00100;
    step();
    step();
    chk("rst_s", s, 5'b00000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_changed", changed, 1'b0);

    // Warm-up: valid on the 4th edge after release.
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("warm_valid", valid, (k == 4) ? 1'b1 : 1'b0);
      chk("warm_changed", changed, 1'b0);
    end
    chk("warm_s", s, 5'b00100);

    // Glitch on bit 3: two 3-clock pulses back to back; neither may pass,
    // the second proving the counter restarted from zero.
    for (int p = 0; p < 2; p++) begin
      raw = 5'b01100;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("glitch_s", s, 5'b00100);
        chk("glitch_changed", changed, 1'b0);
      end
      raw = 5'b00100;
      for (int k = 0; k < 5; k++) begin
        step();
        chk("glitch_s", s, 5'b00100);
        chk("glitch_changed", changed, 1'b0);
      end
    end

    // Latency: raw sampled at edge E, s updates after edge E+5.
    raw = 5'b01100;
    for (int k = 0; k <= 6; k++) begin
      step();
      chk("lat_s", s, (k >= 5) ? 5'b01100 : 5'b00100);
      chk("lat_changed", changed, (k == 5) ? 1'b1 : 1'b0);
    end

    // Sparse tick (every 3rd clock, edges 2,5,8,11): bit 0 qualifies at edge 11.
    raw = 5'b01101;
    for (int k = 0; k <= 12; k++) begin
      tick = (k % 3 == 2);
      step();
      chk("tick_s", s, (k >= 11) ? 5'b01101 : 5'b01100);
      chk("tick_changed", changed, (k == 11) ? 1'b1 : 1'b0);
    end
    tick = 1'b1;

    // Bits 4 and 0 together, bit 1 two clocks later: two separate pulses.
    raw = 5'b11100;
    for (int k = 0; k <= 9; k++) begin
      if (k == 2) raw = 5'b11110;
      step();
      chk("multi_s", s, (k >= 7) ? 5'b11110 : (k >= 5) ? 5'b11100 : 5'b01101);
      chk("multi_changed", changed, (k == 5 || k == 7) ? 1'b1 : 1'b0);
    end

    // Reset mid-count (bit 0 counter at 2), asynchronous drop between edges.
    raw = 5'b11111;
    for (int k = 0; k < 4; k++) step();
    chk("mid_s_pre", s, 5'b11110);
    chk("mid_valid_pre", valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_s", s, 5'b00000);
    chk("async_valid", valid, 1'b0);
    chk("async_changed", changed, 1'b0);
    step();
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("rewarm_valid", valid, (k == 4) ? 1'b1 : 1'b0);
      chk("rewarm_changed", changed, 1'b0);
    end
    chk("rewarm_s", s, 5'b11111);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
